// File: rtl/accel_phase_sequencer.sv
// Descriptor-driven run sequencer. It steps through NUM_PHASES phases, and
// each phase is READ, WRITE, COMPUTE or SKIP. The sequencer launches the AGU
// or the compute unit for each phase and forwards AGU addresses to the memory
// channel. It supports abort and a per-phase timeout, reports an error code,
// and counts the busy cycles of each run.
module accel_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int BANK_WIDTH = 5,
    parameter int TO_WIDTH   = 20,
    parameter int PHW        = $clog2(NUM_PHASES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [2*NUM_PHASES-1:0]          phase_kind,
    input  logic [ADDR_WIDTH*NUM_PHASES-1:0] phase_base,
    input  logic [LEN_WIDTH*NUM_PHASES-1:0]  phase_len,
    input  logic [BANK_WIDTH*NUM_PHASES-1:0] phase_bank,
    input  logic [TO_WIDTH-1:0]              timeout_limit,
    output logic                             agu_start,
    output logic [ADDR_WIDTH-1:0]            agu_base,
    output logic [LEN_WIDTH-1:0]             agu_length,
    input  logic                             agu_done,
    input  logic [ADDR_WIDTH-1:0]            agu_addr,
    input  logic                             agu_addr_valid,
    output logic                             agu_addr_ready,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [BANK_WIDTH-1:0]            mem_bank,
    output logic                             mem_re,
    output logic                             mem_we,
    output logic                             compute_start,
    input  logic                             compute_done,
    input  logic [7:0]                       compute_error,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [1:0]                       err_code,
    output logic [PHW-1:0]                   cur_phase,
    output logic [31:0]                      run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_ADVANCE, S_DONE, S_ERROR
    } state_t;

    localparam logic [1:0] K_READ    = 2'd0;
    localparam logic [1:0] K_WRITE   = 2'd1;
    localparam logic [1:0] K_COMPUTE = 2'd2;
    localparam logic [1:0] K_SKIP    = 2'd3;

    state_t state, state_nx;
    logic   start_q;
    logic   launch;

    // Shadow copy of the descriptors, frozen for the whole run
    logic [2*NUM_PHASES-1:0]          sh_kind;
    logic [ADDR_WIDTH*NUM_PHASES-1:0] sh_base;
    logic [LEN_WIDTH*NUM_PHASES-1:0]  sh_len;
    logic [BANK_WIDTH*NUM_PHASES-1:0] sh_bank;

    logic [PHW-1:0]        ph_idx;
    logic [TO_WIDTH-1:0]   to_cnt;
    logic [1:0]            err_q, err_nx;
    logic [31:0]           run_cnt;

    logic [1:0]            cur_kind;
    logic [ADDR_WIDTH-1:0] cur_base;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic [BANK_WIDTH-1:0] cur_bank;
    logic                  is_mem, is_empty, is_last, ph_done, to_hit;

    assign launch   = start & ~start_q;
    assign cur_kind = sh_kind[ph_idx*2 +: 2];
    assign cur_base = sh_base[ph_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign cur_len  = sh_len[ph_idx*LEN_WIDTH +: LEN_WIDTH];
    assign cur_bank = sh_bank[ph_idx*BANK_WIDTH +: BANK_WIDTH];

    assign is_mem   = (cur_kind == K_READ) || (cur_kind == K_WRITE);
    assign is_empty = (cur_kind == K_SKIP) || (is_mem && (cur_len == '0));
    assign is_last  = (ph_idx == PHW'(NUM_PHASES - 1));
    assign ph_done  = is_mem ? agu_done : ((cur_kind == K_COMPUTE) && compute_done);
    assign to_hit   = (timeout_limit != '0) &&
                      (to_cnt == timeout_limit - TO_WIDTH'(1)) && !ph_done;

    assign err_code   = err_q;
    assign cur_phase  = ph_idx;
    assign run_cycles = run_cnt;

    // State register; start_q resets high so a start held through reset is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            start_q <= 1'b1;
        end else begin
            state   <= state_nx;
            start_q <= start;
        end
    end

    // Next state and all strobes/outputs; abort beats phase completion, which beats timeout
    always_comb begin
        state_nx       = state;
        err_nx         = err_q;
        agu_start      = 1'b0;
        compute_start  = 1'b0;
        agu_base       = '0;
        agu_length     = '0;
        agu_addr_ready = 1'b0;
        mem_addr       = '0;
        mem_bank       = '0;
        mem_re         = 1'b0;
        mem_we         = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) state_nx = S_LAUNCH;
            end
            S_LAUNCH: begin
                busy       = 1'b1;
                agu_base   = cur_base;
                agu_length = cur_len;
                if (abort) begin
                    state_nx = S_ERROR;
                    err_nx   = 2'd3;
                end else if (is_empty) begin
                    state_nx = S_ADVANCE;
                end else begin
                    // a non-empty, non-memory phase can only be COMPUTE
                    agu_start     = is_mem;
                    compute_start = !is_mem;
                    state_nx      = S_RUN;
                end
            end
            S_RUN: begin
                busy       = 1'b1;
                agu_base   = cur_base;
                agu_length = cur_len;
                if (is_mem) begin
                    agu_addr_ready = 1'b1;
                    mem_addr       = agu_addr;
                    mem_bank       = cur_bank;
                    mem_re         = agu_addr_valid && (cur_kind == K_READ);
                    mem_we         = agu_addr_valid && (cur_kind == K_WRITE);
                end
                if (abort) begin
                    state_nx = S_ERROR;
                    err_nx   = 2'd3;
                end else if (ph_done) begin
                    if (!is_mem && (compute_error != 8'd0)) begin
                        state_nx = S_ERROR;
                        err_nx   = 2'd1;
                    end else begin
                        state_nx = S_ADVANCE;
                    end
                end else if (to_hit) begin
                    state_nx = S_ERROR;
                    err_nx   = 2'd2;
                end
            end
            S_ADVANCE: begin
                busy = 1'b1;
                if (abort) begin
                    state_nx = S_ERROR;
                    err_nx   = 2'd3;
                end else if (is_last) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_LAUNCH;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_nx = S_IDLE;
            end
            S_ERROR: begin
                error = 1'b1;
                if (!start) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Run datapath: descriptor capture, phase index, timeout and busy-cycle counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_kind <= '0;
            sh_base <= '0;
            sh_len  <= '0;
            sh_bank <= '0;
            ph_idx  <= '0;
            to_cnt  <= '0;
            err_q   <= 2'd0;
            run_cnt <= 32'd0;
        end else begin
            err_q <= err_nx;
            if (state == S_IDLE && launch) begin
                sh_kind <= phase_kind;
                sh_base <= phase_base;
                sh_len  <= phase_len;
                sh_bank <= phase_bank;
                ph_idx  <= '0;
                run_cnt <= 32'd0;
                err_q   <= 2'd0;
            end else if (busy && run_cnt != 32'hFFFF_FFFF) begin
                run_cnt <= run_cnt + 32'd1;
            end
            if (state == S_ADVANCE && state_nx == S_LAUNCH) ph_idx <= ph_idx + PHW'(1);
            if (state == S_LAUNCH)   to_cnt <= '0;
            else if (state == S_RUN) to_cnt <= to_cnt + TO_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_accel_phase_sequencer.sv
// Bench for accel_phase_sequencer. An AGU/compute responder model drives
// addresses and completions. Every address handed to the sequencer queues
// the memory strobe it should produce, and the monitor pops and compares
// that entry when the strobe appears.
module tb_accel_phase_sequencer;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int BW = 5;
    localparam int TW = 20;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] bank;
    } mem_item_t;

    logic            clk = 1'b0;
    logic            rst_n, start, abort;
    logic [2*NP-1:0] phase_kind;
    logic [AW*NP-1:0] phase_base;
    logic [LW*NP-1:0] phase_len;
    logic [BW*NP-1:0] phase_bank;
    logic [TW-1:0]   timeout_limit;
    logic            agu_start, agu_done, agu_addr_valid, agu_addr_ready;
    logic [AW-1:0]   agu_base, agu_addr, mem_addr;
    logic [LW-1:0]   agu_length;
    logic [BW-1:0]   mem_bank;
    logic            mem_re, mem_we, compute_start, compute_done;
    logic [7:0]      compute_error;
    logic            busy, done, error;
    logic [1:0]      err_code;
    logic [1:0]      cur_phase;
    logic [31:0]     run_cycles;

    accel_phase_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .phase_kind(phase_kind), .phase_base(phase_base), .phase_len(phase_len),
        .phase_bank(phase_bank), .timeout_limit(timeout_limit),
        .agu_start(agu_start), .agu_base(agu_base), .agu_length(agu_length),
        .agu_done(agu_done), .agu_addr(agu_addr), .agu_addr_valid(agu_addr_valid),
        .agu_addr_ready(agu_addr_ready), .mem_addr(mem_addr), .mem_bank(mem_bank),
        .mem_re(mem_re), .mem_we(mem_we), .compute_start(compute_start),
        .compute_done(compute_done), .compute_error(compute_error),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .cur_phase(cur_phase), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    // descriptor tables and responder configuration (written by the main thread)
    logic [1:0]    t_kind [NP];
    logic [AW-1:0] t_base [NP];
    logic [LW-1:0] t_len  [NP];
    logic [BW-1:0] t_bank [NP];
    int            comp_lat = 0;
    logic [7:0]    comp_err = 8'd0;
    int            abort_ph = -1;

    // monitor-owned state
    mem_item_t mem_q[$];
    int  n_chk = 0, n_pass = 0;
    int  cyc = 0, n_agu = 0, n_comp = 0, n_re = 0, n_we = 0, n_done = 0;
    int  t_cs = 0, t_err = 0, exp_p = -1, act_p = 0;
    bit  seen_agu = 0, seen_comp = 0, busy_q = 0, err_q = 0;

    // responder-owned state
    bit            a_act = 0, c_act = 0;
    int            a_p = 0, c_rem = 0;
    logic [AW-1:0] a_addr = '0;
    logic [LW-1:0] a_rem = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    endtask

    function automatic bit is_empty(input int p);
        return (t_kind[p] == 2'd3) || ((t_kind[p] < 2'd2) && (t_len[p] == '0));
    endfunction

    task automatic set_ph(input int i, input logic [1:0] k, input logic [AW-1:0] b,
                          input logic [LW-1:0] l, input logic [BW-1:0] bk);
        t_kind[i] = k; t_base[i] = b; t_len[i] = l; t_bank[i] = bk;
    endtask

    task automatic apply_desc();
        for (int i = 0; i < NP; i++) begin
            phase_kind[i*2 +: 2]  = t_kind[i];
            phase_base[i*AW +: AW] = t_base[i];
            phase_len[i*LW +: LW]  = t_len[i];
            phase_bank[i*BW +: BW] = t_bank[i];
        end
    endtask

    task automatic wait_end(input int max_cyc);
        int n = 0;
        while (!(done || error) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("run_end", 64'(done || error), 64'(1));
        #1;
    endtask

    task automatic end_run();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_flags", 64'({done, error}), 64'(0));
    endtask

    // AGU / compute responder: reacts to strobes seen by the monitor last cycle
    initial begin
        agu_done = 0; agu_addr_valid = 0; agu_addr = '0;
        compute_done = 0; compute_error = '0; abort = 0;
        forever begin
            @(posedge clk); #1;
            agu_done = 0; agu_addr_valid = 0; agu_addr = '0;
            compute_done = 0; compute_error = '0; abort = 0;
            if (!rst_n) begin
                a_act = 0; c_act = 0;
            end else begin
                if (seen_agu) begin
                    a_act = 1; a_p = act_p; a_addr = t_base[act_p]; a_rem = t_len[act_p];
                end
                if (seen_comp) begin
                    c_act = (comp_lat != 0); c_rem = comp_lat;
                end
                if (a_act) begin
                    if (a_rem != '0) begin
                        agu_addr_valid = 1; agu_addr = a_addr;
                        a_addr = a_addr + 1; a_rem = a_rem - 1;
                    end else begin
                        agu_done = 1; a_act = 0;
                        if (abort_ph == a_p) abort = 1;
                    end
                end
                if (c_act) begin
                    c_rem--;
                    if (c_rem == 0) begin
                        compute_done = 1; compute_error = comp_err; c_act = 0;
                    end
                end
            end
        end
    end

    // Monitor: launch checks, scoreboard push on stimulus, pop on memory strobe
    initial begin
        mem_item_t e;
        int p;
        forever begin
            @(negedge clk);
            cyc++;
            seen_agu  = agu_start;
            seen_comp = compute_start;
            if (!rst_n) begin
                mem_q.delete();
                busy_q = 0; err_q = 0;
            end else begin
                if (busy && !busy_q) begin
                    chk("rc_start", 64'(run_cycles), 64'(0));
                    exp_p = -1;
                end
                busy_q = busy;
                if (agu_start || compute_start) begin
                    p = exp_p + 1;
                    while (p < NP && is_empty(p)) p++;
                    exp_p = p;
                    if (p >= NP) begin
                        chk("extra_launch", 64'(1), 64'(0));
                        act_p = 0;
                    end else begin
                        act_p = p;
                        chk("launch_phase", 64'(cur_phase), 64'(p));
                        chk("strobe_kind", 64'({agu_start, compute_start}),
                            64'((t_kind[p] == 2'd2) ? 2'b01 : 2'b10));
                        if (agu_start) begin
                            chk("agu_base", 64'(agu_base), 64'(t_base[p]));
                            chk("agu_len", 64'(agu_length), 64'(t_len[p]));
                        end
                    end
                    if (agu_start) n_agu++;
                    if (compute_start) begin n_comp++; t_cs = cyc; end
                end
                if (agu_addr_valid && a_act) begin
                    e.we = (t_kind[a_p] == 2'd1); e.addr = agu_addr; e.bank = t_bank[a_p];
                    mem_q.push_back(e);
                end
                if (mem_re || mem_we) begin
                    if (mem_re) n_re++;
                    if (mem_we) n_we++;
                    if (mem_q.size() == 0) begin
                        chk("mem_extra", 64'(1), 64'(0));
                    end else begin
                        e = mem_q.pop_front();
                        chk("mem_dir", 64'({mem_re, mem_we}), 64'({!e.we, e.we}));
                        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                        chk("mem_bank", 64'(mem_bank), 64'(e.bank));
                        chk("addr_ready", 64'(agu_addr_ready), 64'(1));
                    end
                end
                if (error && !err_q) t_err = cyc;
                err_q = error;
                if (done) n_done++;
            end
        end
    end

    initial begin
        int b_agu, b_comp, b_re, b_we, b_done;
        int n;
        rst_n = 0; start = 1; timeout_limit = '0;
        phase_kind = '0; phase_base = '0; phase_len = '0; phase_bank = '0;
        for (int i = 0; i < NP; i++) set_ph(i, 2'd3, '0, '0, '0);

        // reset with start held high: outputs quiet, and no run after release
        repeat (2) @(negedge clk);
        chk("rst_outs", 64'({busy, done, error, agu_start, compute_start, mem_re, mem_we}), 64'(0));
        chk("rst_phase", 64'(cur_phase), 64'(0));
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("hold_start_busy", 64'(busy), 64'(0));
        chk("hold_start_rc", 64'(run_cycles), 64'(0));
        start = 0;
        @(negedge clk);

        // A: READ, READ, COMPUTE, WRITE
        set_ph(0, 2'd0, 32'h100, 16'd4, 5'd2);
        set_ph(1, 2'd0, 32'h200, 16'd3, 5'd3);
        set_ph(2, 2'd2, 32'h0,   16'd0, 5'd0);
        set_ph(3, 2'd1, 32'h300, 16'd2, 5'd7);
        apply_desc(); comp_lat = 5; comp_err = 8'd0;
        b_agu = n_agu; b_comp = n_comp; b_re = n_re; b_we = n_we;
        start = 1;
        wait_end(300);
        chk("A_done", 64'({done, error}), 64'(2'b10));
        chk("A_err", 64'(err_code), 64'(0));
        chk("A_agu_starts", 64'(n_agu - b_agu), 64'(3));
        chk("A_comp_starts", 64'(n_comp - b_comp), 64'(1));
        chk("A_re_cycles", 64'(n_re - b_re), 64'(7));
        chk("A_we_cycles", 64'(n_we - b_we), 64'(2));
        chk("A_q_empty", 64'(mem_q.size()), 64'(0));
        // per phase: LAUNCH + (len addresses + done cycle) + ADVANCE; compute: 1+5+1
        chk("A_run_cycles", 64'(run_cycles), 64'(7 + 6 + 7 + 5));
        end_run();

        // C: timeout on a compute phase that never completes
        set_ph(0, 2'd0, 32'h10, 16'd1, 5'd1);
        set_ph(1, 2'd3, 32'h0,  16'd0, 5'd0);
        set_ph(2, 2'd2, 32'h0,  16'd0, 5'd0);
        set_ph(3, 2'd1, 32'h20, 16'd1, 5'd1);
        apply_desc(); comp_lat = 0; timeout_limit = 20'd10;
        start = 1;
        wait_end(300);
        chk("C_error", 64'({done, error}), 64'(2'b01));
        chk("C_err", 64'(err_code), 64'(2));
        chk("C_phase", 64'(cur_phase), 64'(2));
        // compute_start sample, then 10 RUN cycles, then ERROR
        chk("C_to_latency", 64'(t_err - t_cs), 64'(11));
        end_run();
        timeout_limit = '0;

        // D: abort in phase 1 in the same cycle as agu_done
        set_ph(0, 2'd0, 32'h40, 16'd2, 5'd1);
        set_ph(1, 2'd0, 32'h80, 16'd3, 5'd4);
        set_ph(2, 2'd2, 32'h0,  16'd0, 5'd0);
        set_ph(3, 2'd1, 32'hC0, 16'd2, 5'd5);
        apply_desc(); comp_lat = 2; abort_ph = 1;
        b_done = n_done; b_comp = n_comp;
        start = 1;
        wait_end(300);
        chk("D_error", 64'({done, error}), 64'(2'b01));
        chk("D_err", 64'(err_code), 64'(3));
        chk("D_phase", 64'(cur_phase), 64'(1));
        chk("D_no_compute", 64'(n_comp - b_comp), 64'(0));
        end_run();
        chk("D_never_done", 64'(n_done - b_done), 64'(0));
        abort_ph = -1;

        // E: compute fault, then a fresh run of empty phases (B)
        set_ph(0, 2'd0, 32'h20, 16'd1, 5'd0);
        set_ph(1, 2'd2, 32'h0,  16'd0, 5'd0);
        set_ph(2, 2'd3, 32'h0,  16'd0, 5'd0);
        set_ph(3, 2'd3, 32'h0,  16'd0, 5'd0);
        apply_desc(); comp_lat = 3; comp_err = 8'h04;
        start = 1;
        wait_end(300);
        chk("E_error", 64'({done, error}), 64'(2'b01));
        chk("E_err", 64'(err_code), 64'(1));
        chk("E_phase", 64'(cur_phase), 64'(1));
        end_run();
        comp_err = 8'd0;

        set_ph(0, 2'd0, 32'h50, 16'd0, 5'd3);
        set_ph(1, 2'd3, 32'h60, 16'd5, 5'd3);
        set_ph(2, 2'd1, 32'h70, 16'd0, 5'd3);
        set_ph(3, 2'd3, 32'h0,  16'd0, 5'd0);
        apply_desc();
        b_agu = n_agu; b_comp = n_comp;
        start = 1;
        wait_end(100);
        chk("B_done", 64'({done, error}), 64'(2'b10));
        chk("B_err", 64'(err_code), 64'(0));
        chk("B_no_strobes", 64'((n_agu - b_agu) + (n_comp - b_comp)), 64'(0));
        chk("B_run_cycles", 64'(run_cycles), 64'(8));
        end_run();

        // F: asynchronous reset in the middle of a READ phase
        set_ph(0, 2'd0, 32'h500, 16'd6, 5'd9);
        set_ph(1, 2'd3, 32'h0,   16'd0, 5'd0);
        set_ph(2, 2'd3, 32'h0,   16'd0, 5'd0);
        set_ph(3, 2'd3, 32'h0,   16'd0, 5'd0);
        apply_desc();
        start = 1;
        n = 0;
        while (!mem_re && n < 50) begin @(negedge clk); n++; end
        chk("F_reached_run", 64'(mem_re), 64'(1));
        rst_n = 0;
        #1;
        chk("F_rst_flags", 64'({busy, done, error, agu_start, compute_start, agu_addr_ready}), 64'(0));
        chk("F_rst_mem", 64'({mem_re, mem_we, mem_addr, mem_bank}), 64'(0));
        chk("F_rst_agu", 64'({agu_base, agu_length}), 64'(0));
        chk("F_rst_state", 64'({err_code, cur_phase, run_cycles}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (5) @(negedge clk);
        chk("F_no_rerun", 64'(busy), 64'(0));
        start = 0;
        repeat (2) @(negedge clk);
        chk("final_q_empty", 64'(mem_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
